csi_tx_pkt_builder: RTL and testbench

//  Transmit-side CSI-2 packetizer, one byte per beat. Builds the 4-byte packet header: DI, WC lo, WC hi, ECC.
//  For long packets it forwards WC payload bytes, then appends CRC-16 (lo, hi). Short packets are header only.

---
 rtl/csi_tx_pkt_builder.sv | 178 +++++++++++++++++
 tb/tb_csi_tx_pkt_builder.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csi_tx_pkt_builder.sv
// CSI-2 transmit packetizer: emits DI/WC/ECC header, forwards long-packet payload,
// and appends the reflected CRC-16, one byte per beat.
module csi_tx_pkt_builder #(
  parameter logic [5:0]  LONG_DT_MIN = 6'h10,
  parameter logic [15:0] CRC_SEED    = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hdr_valid,
  output logic        hdr_ready,
  input  logic [1:0]  hdr_vc,
  input  logic [5:0]  hdr_dt,
  input  logic [15:0] hdr_wc,
  input  logic        pl_valid,
  output logic        pl_ready,
  input  logic [7:0]  pl_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        out_sop,
  output logic        out_eop,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_PAYLOAD,
    S_CRC_LO,
    S_CRC_HI
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [1:0]  vc_q, vc_d;
  logic [5:0]  dt_q, dt_d;
  logic [15:0] wc_q, wc_d;
  logic [7:0]  ecc_q, ecc_d;
  logic [15:0] rem_q, rem_d;
  logic [15:0] crc_q, crc_d;
  logic        is_long;

  // Hamming-style parity masks over D[23:0]; bit n of a mask selects D[n].
  function automatic logic [7:0] ecc_calc(input logic [23:0] d);
    return {2'b00,
            ^(d & 24'hEFFC00),
            ^(d & 24'hDF03F0),
            ^(d & 24'hB8E38E),
            ^(d & 24'h749A6D),
            ^(d & 24'hF2555B),
            ^(d & 24'hF12CB7)};
  endfunction

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ 16'h8408) : (r >> 1);
    end
    return r;
  endfunction

  assign is_long = (dt_q >= LONG_DT_MIN);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values; combinational blocks use blocking assignments.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= 2'd0;
      vc_q    <= 2'd0;
      dt_q    <= 6'd0;
      wc_q    <= 16'd0;
      ecc_q   <= 8'd0;
      rem_q   <= 16'd0;
      crc_q   <= CRC_SEED;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      vc_q    <= vc_d;
      dt_q    <= dt_d;
      wc_q    <= wc_d;
      ecc_q   <= ecc_d;
      rem_q   <= rem_d;
      crc_q   <= crc_d;
    end
  end

  // NOTE: every variable gets a default before the case so no path infers a latch.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    vc_d    = vc_q;
    dt_d    = dt_q;
    wc_d    = wc_q;
    ecc_d   = ecc_q;
    rem_d   = rem_q;
    crc_d   = crc_q;
    case (state_q)
      S_IDLE: begin
        if (hdr_valid) begin
          vc_d    = hdr_vc;
          dt_d    = hdr_dt;
          wc_d    = hdr_wc;
          ecc_d   = ecc_calc({hdr_wc, hdr_vc, hdr_dt});
          rem_d   = hdr_wc;
          crc_d   = CRC_SEED;
          idx_d   = 2'd0;
          state_d = S_HDR;
        end
      end
      S_HDR: begin
        if (out_ready) begin
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            if (!is_long)            state_d = S_IDLE;
            else if (wc_q == 16'd0)  state_d = S_CRC_LO;
            else                     state_d = S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        if (pl_valid && out_ready) begin
          crc_d = crc_step(crc_q, pl_data);
          rem_d = rem_q - 16'd1;
          if (rem_q == 16'd1) state_d = S_CRC_LO;
        end
      end
      S_CRC_LO: if (out_ready) state_d = S_CRC_HI;
      S_CRC_HI: if (out_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Header and CRC bytes come from registers only, so they hold while stalled.
  always_comb begin
    hdr_ready = 1'b0;
    pl_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = 8'd0;
    out_sop   = 1'b0;
    out_eop   = 1'b0;
    busy      = 1'b1;
    case (state_q)
      S_IDLE: begin
        hdr_ready = 1'b1;
        busy      = 1'b0;
      end
      S_HDR: begin
        out_valid = 1'b1;
        out_sop   = (idx_q == 2'd0);
        out_eop   = (idx_q == 2'd3) && !is_long;
        case (idx_q)
          2'd0:    out_data = {vc_q, dt_q};
          2'd1:    out_data = wc_q[7:0];
          2'd2:    out_data = wc_q[15:8];
          default: out_data = ecc_q;
        endcase
      end
      S_PAYLOAD: begin
        pl_ready  = out_ready;
        out_valid = pl_valid;
        out_data  = pl_data;
      end
      S_CRC_LO: begin
        out_valid = 1'b1;
        out_data  = crc_q[7:0];
      end
      S_CRC_HI: begin
        out_valid = 1'b1;
        out_data  = crc_q[15:8];
        out_eop   = 1'b1;
      end
      default: busy = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_csi_tx_pkt_builder.sv
// Self-checking bench for csi_tx_pkt_builder: a packet-level model predicts the byte
// stream, and a per-cycle monitor compares every transferred byte and stall behaviour.
module tb_csi_tx_pkt_builder;

  logic        clk;
  logic        rst_n;
  logic        hdr_valid;
  logic        hdr_ready;
  logic [1:0]  hdr_vc;
  logic [5:0]  hdr_dt;
  logic [15:0] hdr_wc;
  logic        pl_valid;
  logic        pl_ready;
  logic [7:0]  pl_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_sop;
  logic        out_eop;
  logic        busy;

  csi_tx_pkt_builder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .hdr_valid (hdr_valid),
    .hdr_ready (hdr_ready),
    .hdr_vc    (hdr_vc),
    .hdr_dt    (hdr_dt),
    .hdr_wc    (hdr_wc),
    .pl_valid  (pl_valid),
    .pl_ready  (pl_ready),
    .pl_data   (pl_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sop   (out_sop),
    .out_eop   (out_eop),
    .busy      (busy)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       sop;
    logic       eop;
  } beat_t;

  beat_t      exp_q[$];
  logic [7:0] pl_buf[0:511];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         busy_cnt = 0;
  int         last_busy_len = 0;
  int         last_eop_cyc = 0;
  int         last_gap = 0;
  int         pl_ready_seen = 0;
  bit         stall_en = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for DUT (t=%0t)", name, $time);
  endtask

  // ---------------- packet-level model ----------------
  function automatic bit in_list(input int e, input int b);
    case (e)
      5:       return (b >= 10 && b <= 19) || b == 21 || b == 22 || b == 23;
      4:       return (b >= 4 && b <= 9) || (b >= 16 && b <= 20) || b == 22 || b == 23;
      3:       return b inside {1, 2, 3, 7, 8, 9, 13, 14, 15, 19, 20, 21, 23};
      2:       return b inside {0, 2, 3, 5, 6, 9, 11, 12, 15, 18, 20, 21, 22};
      1:       return b inside {0, 1, 3, 4, 6, 8, 10, 12, 14, 17, 20, 21, 22, 23};
      default: return b inside {0, 1, 2, 4, 5, 7, 10, 11, 13, 16, 20, 21, 22, 23};
    endcase
  endfunction

  function automatic logic [7:0] ecc_model(input logic [23:0] d);
    logic [7:0] e;
    e = 8'd0;
    for (int k = 0; k < 6; k++)
      for (int b = 0; b < 24; b++)
        if (in_list(k, b)) e[k] = e[k] ^ d[b];
    return e;
  endfunction

  function automatic logic [15:0] crc_model(input int n);
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    for (int i = 0; i < n; i++)
      for (int k = 0; k < 8; k++) begin
        fb = c[0] ^ pl_buf[i][k];
        c  = c >> 1;
        if (fb) c = c ^ 16'h8408;
      end
    return c;
  endfunction

  task automatic build_expected(input logic [1:0] vc, input logic [5:0] dt, input logic [15:0] wc);
    logic [7:0]  di;
    logic [15:0] crc;
    bit          long_pkt;
    di       = {vc, dt};
    long_pkt = (dt >= 6'h10);
    exp_q.push_back('{di, 1'b1, 1'b0});
    exp_q.push_back('{wc[7:0], 1'b0, 1'b0});
    exp_q.push_back('{wc[15:8], 1'b0, 1'b0});
    exp_q.push_back('{ecc_model({wc, di}), 1'b0, !long_pkt});
    if (long_pkt) begin
      for (int i = 0; i < int'(wc); i++) exp_q.push_back('{pl_buf[i], 1'b0, 1'b0});
      crc = crc_model(int'(wc));
      exp_q.push_back('{crc[7:0], 1'b0, 1'b0});
      exp_q.push_back('{crc[15:8], 1'b0, 1'b1});
    end
  endtask

  // ---------------- per-cycle compare ----------------
  initial begin : monitor
    bit    prev_stall;
    beat_t prev;
    beat_t e;
    prev_stall = 0;
    prev       = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        prev_stall = 0;
        busy_cnt   = 0;
      end else begin
        check("hdr_ready_vs_busy", hdr_ready, !busy);
        if (pl_ready) pl_ready_seen++;
        if (prev_stall) begin
          check("stall_valid_held", out_valid, 1'b1);
          check("stall_beat_held", {out_data, out_sop, out_eop}, {prev.data, prev.sop, prev.eop});
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_byte: got %0h with no byte expected (t=%0t)", out_data, $time);
          end else begin
            e = exp_q.pop_front();
            check("out_beat", {out_data, out_sop, out_eop}, {e.data, e.sop, e.eop});
          end
          if (out_sop) last_gap = cyc - last_eop_cyc;
          if (out_eop) last_eop_cyc = cyc;
        end
        if (busy) busy_cnt++;
        else if (busy_cnt > 0) begin
          last_busy_len = busy_cnt;
          busy_cnt      = 0;
        end
        prev_stall = out_valid && !out_ready;
        prev       = '{out_data, out_sop, out_eop};
      end
    end
  end

  initial begin : ready_driver
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  // ---------------- stimulus ----------------
  task automatic run_pkt(input logic [1:0] vc, input logic [5:0] dt, input logic [15:0] wc,
                         input int abort_at, input bit drain);
    bit acc;
    int n;
    build_expected(vc, dt, wc);
    hdr_vc    = vc;
    hdr_dt    = dt;
    hdr_wc    = wc;
    hdr_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk); acc = hdr_ready;
      @(posedge clk); #1; n++;
    end while (!acc && n < 2000);
    hdr_valid = 1'b0;
    if (!acc) begin timeout_fail("hdr_accept"); return; end
    if (dt >= 6'h10) begin
      for (int i = 0; i < int'(wc); i++) begin
        if (i == abort_at) begin pl_valid = 1'b0; return; end
        if (stall_en && $urandom_range(0, 3) == 0) begin
          pl_valid = 1'b0;
          @(posedge clk); #1;
        end
        pl_valid = 1'b1;
        pl_data  = pl_buf[i];
        n = 0;
        do begin
          @(negedge clk); acc = pl_ready;
          @(posedge clk); #1; n++;
        end while (!acc && n < 200);
        if (!acc) begin pl_valid = 1'b0; timeout_fail("pl_accept"); return; end
      end
      pl_valid = 1'b0;
    end
    if (drain) begin
      n = 0;
      while (exp_q.size() != 0 && n < 2000) begin @(posedge clk); n++; end
      if (exp_q.size() != 0) timeout_fail("drain");
      repeat (2) @(posedge clk);
      #1;
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check(name, {hdr_ready, pl_ready, out_valid, out_sop, out_eop, busy, out_data},
          {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00});
  endtask

  task automatic load_t3;
    logic [7:0] t3 [24];
    t3 = '{8'hFF, 8'h00, 8'h00, 8'h02, 8'hB9, 8'hDC, 8'hF3, 8'h72, 8'hBB, 8'hD4, 8'hB8, 8'h5A,
           8'hC8, 8'h75, 8'hC2, 8'h7C, 8'h81, 8'hF8, 8'h05, 8'hDF, 8'hFF, 8'h00, 8'h00, 8'h01};
    for (int i = 0; i < 24; i++) pl_buf[i] = t3[i];
  endtask

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    rst_n     = 1'b0;
    hdr_valid = 1'b0;
    hdr_vc    = 2'd0;
    hdr_dt    = 6'd0;
    hdr_wc    = 16'd0;
    pl_valid  = 1'b0;
    pl_data   = 8'd0;
    for (int i = 0; i < 512; i++) pl_buf[i] = 8'(i * 37 + 11);

    repeat (2) @(negedge clk);
    check_reset_outputs("reset_state");
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // Model pinned against hand-computed values.
    check("ecc_model_short", ecc_model(24'h000100), 8'h1A);
    check("ecc_model_2B_0140", ecc_model(24'h01402B), 8'h0C);
    load_t3();
    check("crc_model_t3", crc_model(24), 16'h00F0);

    // 1: short packet, 4 busy cycles.
    run_pkt(2'd0, 6'h00, 16'h0001, -1, 1);
    check("t1_busy_len", last_busy_len, 4);

    // 2: long packet, 320 payload bytes.
    for (int i = 0; i < 320; i++) pl_buf[i] = 8'(i * 13 + 5);
    run_pkt(2'd0, 6'h2B, 16'h0140, -1, 1);
    check("t2_busy_len", last_busy_len, 4 + 320 + 2);

    // 3: reference payload; CRC bytes F0 00.
    load_t3();
    run_pkt(2'd0, 6'h2A, 16'h0018, -1, 1);
    check("t3_busy_len", last_busy_len, 4 + 24 + 2);

    // 4: long packet with no payload; pl_valid held high must be ignored.
    pl_ready_seen = 0;
    pl_valid      = 1'b1;
    pl_data       = 8'h55;
    run_pkt(2'd1, 6'h2A, 16'h0000, -1, 1);
    pl_valid      = 1'b0;
    check("t4_pl_ready_never", pl_ready_seen, 0);
    check("t4_busy_len", last_busy_len, 6);

    // 5: test 3 stream under random output and payload stalls.
    stall_en = 1;
    load_t3();
    run_pkt(2'd0, 6'h2A, 16'h0018, -1, 1);
    stall_en = 0;
    @(posedge clk); #1;

    // Back-to-back short packets: exactly one idle beat between eop and next sop.
    run_pkt(2'd2, 6'h05, 16'hA5C3, -1, 0);
    run_pkt(2'd3, 6'h0F, 16'h1234, -1, 1);
    check("b2b_gap", last_gap, 2);

    // 6: reset at payload byte 10, then a clean packet.
    for (int i = 0; i < 40; i++) pl_buf[i] = 8'($urandom_range(0, 255));
    run_pkt(2'd1, 6'h24, 16'd40, 10, 0);
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check_reset_outputs("t6_reset_mid_packet");
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    run_pkt(2'd1, 6'h24, 16'd40, -1, 1);
    check("t6_clean_busy_len", last_busy_len, 4 + 40 + 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
